// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic-computing encoder/decoder blocks.
//   decode_state_t : decoder window FSM states
//   acc_width()    : width of a signed window count able to hold -N..+N,
//                    where N = 2**log2
package stoch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } decode_state_t;

  // One bit covers the extra magnitude of +N itself, one more is the sign.
  function automatic int acc_width(input int log2);
    return log2 + 2;
  endfunction

endpackage

// File: rtl/stoch_signed_counter.sv
// Per-channel signed up/down accumulator for one p/m stochastic stream pair.
// Ports:
//   CLK, RST    : clock, asynchronous active-high reset
//   clr_i       : synchronous clear (takes priority over en_i)
//   en_i        : a sample is accepted this cycle
//   p_i, m_i    : positive / negative stream bits of the sample
//   acc_next_o  : value the accumulator takes at the next edge; the top
//                 captures the final window value from here so the result
//                 is available in the same cycle as out_valid
module stoch_signed_counter #(
  parameter int ACC_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             p_i,
  input  logic             m_i,
  output logic [ACC_W-1:0] acc_next_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // p=m=1 cancels to zero, so only the exclusive cases move the count.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i && p_i && !m_i) begin
      acc_d = acc_q + ACC_W'(1);
    end else if (en_i && m_i && !p_i) begin
      acc_d = acc_q - ACC_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/stoch_signed_decode.sv
// Decodes CHANNELS signed stochastic p/m stream pairs into signed counts
// sum(x_p - x_m) over a window of N = 2**WINDOW_LOG2 accepted samples.
// Ports:
//   CLK, RST  : clock, asynchronous active-high reset
//   start     : begin a window (only looked at in IDLE)
//   in_valid  : x_p/x_m carry a sample this cycle
//   x_p, x_m  : positive / negative stream bits, one per channel
//   busy      : high while accumulating a window
//   out_valid : one-cycle pulse, y holds a fresh result
//   y         : per-channel signed count, value = y / N
module stoch_signed_decode
  import stoch_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int WINDOW_LOG2 = 8,
  parameter int CONTINUOUS  = 0,
  localparam int ACC_W      = acc_width(WINDOW_LOG2)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [CHANNELS-1:0]            x_p,
  input  logic [CHANNELS-1:0]            x_m,
  output logic                           busy,
  output logic                           out_valid,
  output logic [CHANNELS-1:0][ACC_W-1:0] y
);

  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WINDOW_LOG2) - 1);

  decode_state_t                  state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CHANNELS-1:0][ACC_W-1:0] y_q;
  logic                           out_valid_q;
  logic [CHANNELS-1:0][ACC_W-1:0] acc_next;

  logic accept;
  logic last_sample;
  logic clr_acc;

  assign accept      = (state_q == ACCUM) && in_valid;
  assign last_sample = accept && (cnt_q == LAST_CNT);
  assign clr_acc     = (state_q == DONE);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      stoch_signed_counter #(
        .ACC_W (ACC_W)
      ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .clr_i      (clr_acc),
        .en_i       (accept),
        .p_i        (x_p[gi]),
        .m_i        (x_m[gi]),
        .acc_next_o (acc_next[gi])
      );
    end
  endgenerate

  // y is captured from the accumulators' next value on the N-th sample edge,
  // so it is already valid during the DONE cycle when out_valid is high.
  // The accumulators themselves are cleared during DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (last_sample) begin
            state_q     <= DONE;
            y_q         <= acc_next;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= (CONTINUOUS != 0) ? ACCUM : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_stoch_signed_decode.sv
// Directed bench for stoch_signed_decode with N=16, 3 channels: a table of
// constant-input windows plus hand-written gap, restart, reset and
// continuous-mode sequences.
module tb_stoch_signed_decode;

  localparam int CH  = 3;
  localparam int WL  = 4;
  localparam int AW  = WL + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;

  logic             start_a = 1'b0, in_valid_a = 1'b0;
  logic [CH-1:0]    xp_a = '0, xm_a = '0;
  logic             busy_a, ov_a;
  logic [CH-1:0][AW-1:0] y_a;

  logic             start_c = 1'b0, in_valid_c = 1'b0;
  logic [CH-1:0]    xp_c = '0, xm_c = '0;
  logic             busy_c, ov_c;
  logic [CH-1:0][AW-1:0] y_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stoch_signed_decode #(.CHANNELS(CH), .WINDOW_LOG2(WL), .CONTINUOUS(0)) dut_a (
    .CLK(clk), .RST(rst), .start(start_a), .in_valid(in_valid_a),
    .x_p(xp_a), .x_m(xm_a), .busy(busy_a), .out_valid(ov_a), .y(y_a)
  );

  stoch_signed_decode #(.CHANNELS(CH), .WINDOW_LOG2(WL), .CONTINUOUS(1)) dut_c (
    .CLK(clk), .RST(rst), .start(start_c), .in_valid(in_valid_c),
    .x_p(xp_c), .x_m(xm_c), .busy(busy_c), .out_valid(ov_c), .y(y_c)
  );

  typedef struct {
    logic [CH-1:0] p;
    logic [CH-1:0] m;
    int            e0, e1, e2;
    string         tag;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ya(input int ch);
    return int'($signed(y_a[ch]));
  endfunction

  // One full window with constant inputs. The start cycle also carries a
  // valid sample that must not be counted (it would make the count 17).
  task automatic run_window(input logic [CH-1:0] p, input logic [CH-1:0] m,
                            input int e0, input int e1, input int e2,
                            input string tag);
    start_a = 1'b1; in_valid_a = 1'b1; xp_a = p; xm_a = m;
    tick();
    start_a = 1'b0;
    chk({tag, "_busy_accum"}, int'(busy_a), 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) chk({tag, "_ov_early"}, int'(ov_a), 0);
    end
    chk({tag, "_ov"}, int'(ov_a), 1);
    chk({tag, "_y0"}, ya(0), e0);
    chk({tag, "_y1"}, ya(1), e1);
    chk({tag, "_y2"}, ya(2), e2);
    chk({tag, "_busy_done"}, int'(busy_a), 0);
    in_valid_a = 1'b0; xp_a = '0; xm_a = '0;
    tick();
    chk({tag, "_ov_pulse"}, int'(ov_a), 0);
    chk({tag, "_y0_hold"}, ya(0), e0);
    chk({tag, "_busy_idle"}, int'(busy_a), 0);
    $display("window %s p=%b m=%b y=%0d,%0d,%0d", tag, p, m, ya(0), ya(1), ya(2));
  endtask

  initial begin
    vecs[0] = '{p: 3'b111, m: 3'b000, e0: 16,  e1: 16,  e2: 16,  tag: "all_p"};
    vecs[1] = '{p: 3'b101, m: 3'b110, e0: 16,  e1: -16, e2: 0,   tag: "mixed"};
    vecs[2] = '{p: 3'b000, m: 3'b111, e0: -16, e1: -16, e2: -16, tag: "all_m"};
    vecs[3] = '{p: 3'b010, m: 3'b000, e0: 0,   e1: 16,  e2: 0,   tag: "ch1_only"};

    // Reset state
    #12;
    chk("rst_ov", int'(ov_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_y", int'(y_a), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy_a), 0);

    // Table-driven constant windows
    for (int v = 0; v < 4; v++) begin
      run_window(vecs[v].p, vecs[v].m, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].tag);
    end

    // in_valid toggling; ch0 alternates p/m per accepted sample, ch1 always p.
    // Invalid cycles carry all-ones p as bait.
    start_a = 1'b1; in_valid_a = 1'b0;
    tick();
    start_a = 1'b0;
    begin
      int acc_n;
      acc_n = 0;
      for (int k = 0; k < 32; k++) begin
        if (k % 2 == 0) begin
          in_valid_a = 1'b1;
          xp_a = {1'b0, 1'b1, (acc_n % 2 == 0)};
          xm_a = {1'b0, 1'b0, (acc_n % 2 == 1)};
          acc_n++;
        end else begin
          in_valid_a = 1'b0; xp_a = 3'b111; xm_a = 3'b000;
        end
        tick();
        chk($sformatf("gap_ov_k%0d", k), int'(ov_a), (k == 30) ? 1 : 0);
        if (k == 30) begin
          chk("gap_y0", ya(0), 0);
          chk("gap_y1", ya(1), 16);
          chk("gap_y2", ya(2), 0);
        end
      end
      $display("window gaps y=%0d,%0d,%0d", ya(0), ya(1), ya(2));
    end
    in_valid_a = 1'b0; xp_a = '0;
    tick();

    // start pulsed mid-window is ignored
    start_a = 1'b1; in_valid_a = 1'b1; xp_a = 3'b001; xm_a = 3'b000;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      start_a = (i == 5);
      tick();
      chk($sformatf("restart_ov_i%0d", i), int'(ov_a), (i == 15) ? 1 : 0);
    end
    start_a = 1'b0;
    chk("restart_y0", ya(0), 16);
    chk("restart_y1", ya(1), 0);
    $display("window restart y=%0d,%0d,%0d", ya(0), ya(1), ya(2));
    in_valid_a = 1'b0; xp_a = '0;
    tick();

    // Reset at sample 9: outputs clear immediately, then a clean window
    start_a = 1'b1; in_valid_a = 1'b1; xp_a = 3'b111; xm_a = 3'b000;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("midrst_busy_pre", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    chk("midrst_y", int'(y_a), 0);
    chk("midrst_ov", int'(ov_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    $display("reset mid-window y=%0d busy=%0d", int'(y_a), busy_a);
    in_valid_a = 1'b0; xp_a = '0;
    tick();
    rst = 1'b0;
    tick();
    run_window(3'b011, 3'b100, 16, 16, -16, "after_rst");

    // Continuous mode: one start, results every 17 cycles
    start_c = 1'b1; in_valid_c = 1'b1; xp_c = 3'b001; xm_c = 3'b000;
    tick();
    start_c = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      chk($sformatf("cont_ov_t%0d", t), int'(ov_c),
          (t == 16 || t == 33 || t == 50) ? 1 : 0);
      if (ov_c) begin
        chk($sformatf("cont_y0_t%0d", t), int'($signed(y_c[0])), 16);
        chk($sformatf("cont_busy_done_t%0d", t), int'(busy_c), 0);
        $display("continuous window at t=%0d y0=%0d", t, int'($signed(y_c[0])));
      end
      if (t == 17) chk("cont_rearm_busy", int'(busy_c), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
